// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg -- shared definitions for the DDR port arbiter.
//   arb_state_e : per-side burst engine state (IDLE -> ISSUE -> BUSY -> IDLE)
//   clog2()     : index width helper, never returns less than 1 so that a
//                 single-channel build still has a legal index vector
//   DEF_*       : default widths used by the top level
package ddr_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } arb_state_e;

   localparam int DEF_DATA_W      = 256;
   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_LEN_W       = 10;
   localparam int DEF_TIMEOUT_CYC = 4096;

   function automatic int clog2(input int value);
      int w;
      int v;
      w = 0;
      v = value - 1;
      while (v > 0) begin
         w = w + 1;
         v = v >> 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ddr_arb_engine.sv
// ddr_arb_engine -- one side (write or read) of the DDR port arbiter.
//   Latches per-channel burst requests (addr/len), picks one pending channel
//   per burst by round robin, runs the IDLE/ISSUE/BUSY handshake with the
//   controller and pulses finish to the grantee.
// Ports:
//   clk, srst            clock, synchronous active-high reset (whole engine)
//   req_i/addr_i/len_i   per-channel request pulse and packed addr/len
//   ready_o              per-channel "no pending burst"
//   burst_req_o/addr/len request towards the controller (ISSUE state)
//   ctrl_ready_i         controller accepts the request
//   ctrl_finish_i        controller reports burst completion (BUSY only)
//   busy_o, active_o     state is BUSY / state is ISSUE or BUSY
//   grant_o              index of the current grantee
//   finish_o             1-cycle finish pulse to the grantee
//   timeout_o            watchdog pulse (only when DDR_ARB_TIMEOUT_EN is defined)
// Build option: DDR_ARB_TIMEOUT_EN enables the BUSY watchdog.
module ddr_arb_engine
   import ddr_arb_pkg::*;
#(
   parameter int NUM_CHNL    = 4,
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 10,
   parameter int TIMEOUT_CYC = 4096,
   localparam int IDX_W      = clog2(NUM_CHNL)
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic [NUM_CHNL-1:0]        req_i,
   input  logic [NUM_CHNL*ADDR_W-1:0] addr_i,
   input  logic [NUM_CHNL*LEN_W-1:0]  len_i,
   output logic [NUM_CHNL-1:0]        ready_o,
   output logic                       burst_req_o,
   output logic [ADDR_W-1:0]          burst_addr_o,
   output logic [LEN_W-1:0]           burst_len_o,
   input  logic                       ctrl_ready_i,
   input  logic                       ctrl_finish_i,
   output logic                       busy_o,
   output logic                       active_o,
   output logic [IDX_W-1:0]           grant_o,
   output logic [NUM_CHNL-1:0]        finish_o,
   output logic                       timeout_o
);

   arb_state_e          state_q, state_d;
   logic [NUM_CHNL-1:0] pending_q, pending_d;
   logic [NUM_CHNL-1:0] cap;
   logic [ADDR_W-1:0]   addr_q [NUM_CHNL];
   logic [ADDR_W-1:0]   addr_d [NUM_CHNL];
   logic [LEN_W-1:0]    len_q  [NUM_CHNL];
   logic [LEN_W-1:0]    len_d  [NUM_CHNL];
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    rr_idx;
   logic                rr_found;
   logic                done;

   // A request is only taken while the channel has nothing pending.
   assign cap = req_i & ~pending_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHNL; gi++) begin : g_chnl
         assign addr_d[gi]   = cap[gi] ? addr_i[gi*ADDR_W +: ADDR_W] : addr_q[gi];
         assign len_d[gi]    = cap[gi] ? len_i[gi*LEN_W +: LEN_W]    : len_q[gi];
         assign finish_o[gi] = done && (grant_q == IDX_W'(gi));
      end
   endgenerate

   // Round robin: scan from farthest to nearest after last_q so that the
   // nearest pending channel overwrites the result. Only real channel
   // numbers (< NUM_CHNL) are ever produced.
   always_comb begin
      int cand;
      cand     = 0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = NUM_CHNL; k >= 1; k--) begin
         cand = int'(last_q) + k;
         if (cand >= NUM_CHNL) cand = cand - NUM_CHNL;
         if (pending_q[cand]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(cand);
         end
      end
   end

`ifdef DDR_ARB_TIMEOUT_EN
   localparam int CNT_W = clog2(TIMEOUT_CYC);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Held at zero while issuing, so the first BUSY cycle sees count 0.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_ISSUE)     cnt_d = '0;
      else if (state_q == ST_BUSY) cnt_d = cnt_q + 1'b1;
   end

   // A real finish in the same cycle takes precedence over the watchdog.
   assign timeout_o = (state_q == ST_BUSY) && !ctrl_finish_i &&
                      (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (srst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   // Watchdog absent: the expression is constant 0 (TIMEOUT_CYC is never negative).
   assign timeout_o = (TIMEOUT_CYC < 0);
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      pending_d = pending_q | cap;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rr_found) begin
               grant_d = rr_idx;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ctrl_ready_i) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (ctrl_finish_i || timeout_o) begin
               done               = 1'b1;
               pending_d[grant_q] = 1'b0;
               last_d             = grant_q;
               state_d            = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         grant_q   <= '0;
         last_q    <= IDX_W'(NUM_CHNL - 1);
         for (int i = 0; i < NUM_CHNL; i++) begin
            addr_q[i] <= '0;
            len_q[i]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         for (int i = 0; i < NUM_CHNL; i++) begin
            addr_q[i] <= addr_d[i];
            len_q[i]  <= len_d[i];
         end
      end
   end

   assign ready_o      = ~pending_q;
   assign burst_req_o  = (state_q == ST_ISSUE);
   assign burst_addr_o = addr_q[grant_q];
   assign burst_len_o  = len_q[grant_q];
   assign busy_o       = (state_q == ST_BUSY);
   assign active_o     = (state_q != ST_IDLE);
   assign grant_o      = grant_q;

endmodule

// File: rtl/ddr_port_arbiter_v3.sv
// ddr_port_arbiter_v3 -- N-write / M-read channel arbiter in front of a
// single DDR burst controller. Write and read sides are independent
// ddr_arb_engine instances; this level muxes data and gates handshakes.
// Ports:
//   ui_clk, ui_rst     clock, synchronous active-high reset (whole block)
//   rd_rst             synchronous active-high flush of the read side only
//   Wport_*            per-channel write requests, ready, fifo_re, data, finish
//   Rport_*            per-channel read requests, ready, fifo_we, data, finish
//   wr_* / rd_*        single controller-side burst interface per direction
//   arb_timeout        [0] write / [1] read watchdog pulse
// Build option: DDR_ARB_TIMEOUT_EN enables the BUSY watchdog.
module ddr_port_arbiter_v3
   import ddr_arb_pkg::*;
#(
   parameter int W_NUM_CHNL  = 4,
   parameter int R_NUM_CHNL  = 5,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                         ui_clk,
   input  logic                         ui_rst,
   input  logic                         rd_rst,
   input  logic [W_NUM_CHNL-1:0]        Wport_wr_burst_req,
   input  logic [W_NUM_CHNL*ADDR_W-1:0] Wport_wr_burst_addr,
   input  logic [W_NUM_CHNL*LEN_W-1:0]  Wport_wr_burst_len,
   output logic [W_NUM_CHNL-1:0]        Wport_wr_ready,
   output logic [W_NUM_CHNL-1:0]        Wport_wr_fifo_re,
   input  logic [W_NUM_CHNL*DATA_W-1:0] Wport_wr_fifo_data,
   output logic [W_NUM_CHNL-1:0]        Wport_wr_burst_finish,
   input  logic [R_NUM_CHNL-1:0]        Rport_rd_burst_req,
   input  logic [R_NUM_CHNL*ADDR_W-1:0] Rport_rd_burst_addr,
   input  logic [R_NUM_CHNL*LEN_W-1:0]  Rport_rd_burst_len,
   output logic [R_NUM_CHNL-1:0]        Rport_rd_ready,
   output logic [R_NUM_CHNL-1:0]        Rport_rd_fifo_we,
   output logic [R_NUM_CHNL*DATA_W-1:0] Rport_rd_fifo_data,
   output logic [R_NUM_CHNL-1:0]        Rport_rd_burst_finish,
   output logic                         wr_burst_req,
   output logic [ADDR_W-1:0]            wr_burst_addr,
   output logic [LEN_W-1:0]             wr_burst_len,
   input  logic                         wr_ready,
   input  logic                         wr_fifo_re,
   output logic [DATA_W-1:0]            wr_fifo_data,
   input  logic                         wr_burst_finish,
   output logic                         rd_burst_req,
   output logic [ADDR_W-1:0]            rd_burst_addr,
   output logic [LEN_W-1:0]             rd_burst_len,
   input  logic                         rd_ready,
   input  logic                         rd_fifo_we,
   input  logic [DATA_W-1:0]            rd_fifo_data,
   input  logic                         rd_burst_finish,
   output logic [1:0]                   arb_timeout
);

   localparam int W_IDX_W = clog2(W_NUM_CHNL);
   localparam int R_IDX_W = clog2(R_NUM_CHNL);

   logic               w_busy, w_active, w_timeout;
   logic               r_busy, r_active, r_timeout;
   logic [W_IDX_W-1:0] w_grant;
   logic [R_IDX_W-1:0] r_grant;
   logic [W_NUM_CHNL-1:0] w_finish;
   logic [R_NUM_CHNL-1:0] r_finish;
   logic [DATA_W-1:0]  w_data [W_NUM_CHNL];
   logic               rd_side_rst;

   // rd_rst behaves as a full reset of the read engine only.
   assign rd_side_rst = ui_rst | rd_rst;

   ddr_arb_engine #(
      .NUM_CHNL(W_NUM_CHNL), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wr_engine (
      .clk(ui_clk), .srst(ui_rst),
      .req_i(Wport_wr_burst_req), .addr_i(Wport_wr_burst_addr), .len_i(Wport_wr_burst_len),
      .ready_o(Wport_wr_ready),
      .burst_req_o(wr_burst_req), .burst_addr_o(wr_burst_addr), .burst_len_o(wr_burst_len),
      .ctrl_ready_i(wr_ready), .ctrl_finish_i(wr_burst_finish),
      .busy_o(w_busy), .active_o(w_active), .grant_o(w_grant),
      .finish_o(w_finish), .timeout_o(w_timeout)
   );

   ddr_arb_engine #(
      .NUM_CHNL(R_NUM_CHNL), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_rd_engine (
      .clk(ui_clk), .srst(rd_side_rst),
      .req_i(Rport_rd_burst_req), .addr_i(Rport_rd_burst_addr), .len_i(Rport_rd_burst_len),
      .ready_o(Rport_rd_ready),
      .burst_req_o(rd_burst_req), .burst_addr_o(rd_burst_addr), .burst_len_o(rd_burst_len),
      .ctrl_ready_i(rd_ready), .ctrl_finish_i(rd_burst_finish),
      .busy_o(r_busy), .active_o(r_active), .grant_o(r_grant),
      .finish_o(r_finish), .timeout_o(r_timeout)
   );

   genvar gi;
   generate
      for (gi = 0; gi < W_NUM_CHNL; gi++) begin : g_wr
         assign w_data[gi]           = Wport_wr_fifo_data[gi*DATA_W +: DATA_W];
         assign Wport_wr_fifo_re[gi] = w_busy && wr_fifo_re && (w_grant == W_IDX_W'(gi));
      end
      for (gi = 0; gi < R_NUM_CHNL; gi++) begin : g_rd
         // The flush cycle itself must not leak a beat to the old grantee.
         assign Rport_rd_fifo_we[gi] = r_busy && rd_fifo_we && !rd_rst &&
                                       (r_grant == R_IDX_W'(gi));
      end
   endgenerate

   assign wr_fifo_data          = w_active ? w_data[w_grant] : '0;
   assign Wport_wr_burst_finish = w_finish;
   assign Rport_rd_fifo_data    = {R_NUM_CHNL{rd_fifo_data}};
   assign Rport_rd_burst_finish = r_finish & {R_NUM_CHNL{~rd_rst}};
   assign arb_timeout           = {r_timeout & ~rd_rst & r_active, w_timeout};

endmodule

// File: tb/tb_ddr_port_arbiter_v3.sv
module tb_ddr_port_arbiter_v3;

   localparam int WN = 4;
   localparam int RN = 5;
   localparam int DW = 256;
   localparam int AW = 32;
   localparam int LW = 10;
   localparam int TO = 64;

   logic              ui_clk = 1'b0;
   logic              ui_rst = 1'b1;
   logic              rd_rst = 1'b0;
   logic [WN-1:0]     Wport_wr_burst_req = '0;
   logic [WN*AW-1:0]  Wport_wr_burst_addr = '0;
   logic [WN*LW-1:0]  Wport_wr_burst_len = '0;
   logic [WN-1:0]     Wport_wr_ready;
   logic [WN-1:0]     Wport_wr_fifo_re;
   logic [WN*DW-1:0]  Wport_wr_fifo_data = '0;
   logic [WN-1:0]     Wport_wr_burst_finish;
   logic [RN-1:0]     Rport_rd_burst_req = '0;
   logic [RN*AW-1:0]  Rport_rd_burst_addr = '0;
   logic [RN*LW-1:0]  Rport_rd_burst_len = '0;
   logic [RN-1:0]     Rport_rd_ready;
   logic [RN-1:0]     Rport_rd_fifo_we;
   logic [RN*DW-1:0]  Rport_rd_fifo_data;
   logic [RN-1:0]     Rport_rd_burst_finish;
   logic              wr_burst_req;
   logic [AW-1:0]     wr_burst_addr;
   logic [LW-1:0]     wr_burst_len;
   logic              wr_ready = 1'b0;
   logic              wr_fifo_re = 1'b0;
   logic [DW-1:0]     wr_fifo_data;
   logic              wr_burst_finish = 1'b0;
   logic              rd_burst_req;
   logic [AW-1:0]     rd_burst_addr;
   logic [LW-1:0]     rd_burst_len;
   logic              rd_ready = 1'b0;
   logic              rd_fifo_we = 1'b0;
   logic [DW-1:0]     rd_fifo_data = '0;
   logic              rd_burst_finish = 1'b0;
   logic [1:0]        arb_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   ddr_port_arbiter_v3 #(
      .W_NUM_CHNL(WN), .R_NUM_CHNL(RN), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(TO)
   ) dut (
      .ui_clk(ui_clk), .ui_rst(ui_rst), .rd_rst(rd_rst),
      .Wport_wr_burst_req(Wport_wr_burst_req), .Wport_wr_burst_addr(Wport_wr_burst_addr),
      .Wport_wr_burst_len(Wport_wr_burst_len), .Wport_wr_ready(Wport_wr_ready),
      .Wport_wr_fifo_re(Wport_wr_fifo_re), .Wport_wr_fifo_data(Wport_wr_fifo_data),
      .Wport_wr_burst_finish(Wport_wr_burst_finish),
      .Rport_rd_burst_req(Rport_rd_burst_req), .Rport_rd_burst_addr(Rport_rd_burst_addr),
      .Rport_rd_burst_len(Rport_rd_burst_len), .Rport_rd_ready(Rport_rd_ready),
      .Rport_rd_fifo_we(Rport_rd_fifo_we), .Rport_rd_fifo_data(Rport_rd_fifo_data),
      .Rport_rd_burst_finish(Rport_rd_burst_finish),
      .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
      .wr_ready(wr_ready), .wr_fifo_re(wr_fifo_re), .wr_fifo_data(wr_fifo_data),
      .wr_burst_finish(wr_burst_finish),
      .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
      .rd_ready(rd_ready), .rd_fifo_we(rd_fifo_we), .rd_fifo_data(rd_fifo_data),
      .rd_burst_finish(rd_burst_finish), .arb_timeout(arb_timeout)
   );

   always #5 ui_clk = ~ui_clk;

   task automatic tick();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // One-cycle write request pulse on channel ch.
   task automatic w_req(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l);
      Wport_wr_burst_addr[ch*AW +: AW] = a;
      Wport_wr_burst_len[ch*LW +: LW]  = l;
      Wport_wr_burst_req[ch]           = 1'b1;
      tick();
      Wport_wr_burst_req = '0;
   endtask

   task automatic wait_wr_issue(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (wr_burst_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_rd_issue(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (rd_burst_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      ui_rst = 1'b1;
      wr_fifo_re = 1'b1; rd_fifo_we = 1'b1; wr_burst_finish = 1'b1; rd_burst_finish = 1'b1;
      tick(); tick();
      settle();
      n_checks++; if (Wport_wr_ready !== 4'hF) begin n_fail++; $display("FAIL rst_wready got %h exp %h", Wport_wr_ready, 4'hF); end
      n_checks++; if (Rport_rd_ready !== 5'h1F) begin n_fail++; $display("FAIL rst_rready got %h exp %h", Rport_rd_ready, 5'h1F); end
      n_checks++; if (wr_burst_req !== 1'b0) begin n_fail++; $display("FAIL rst_wreq got %b exp 0", wr_burst_req); end
      n_checks++; if (rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL rst_rreq got %b exp 0", rd_burst_req); end
      n_checks++; if (wr_fifo_data !== '0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", wr_fifo_data); end
      n_checks++; if (arb_timeout !== 2'b00) begin n_fail++; $display("FAIL rst_timeout got %b exp 00", arb_timeout); end
      n_checks++; if (Wport_wr_fifo_re !== 4'h0) begin n_fail++; $display("FAIL rst_fifo_re got %h exp 0", Wport_wr_fifo_re); end
      n_checks++; if (Rport_rd_fifo_we !== 5'h0) begin n_fail++; $display("FAIL rst_fifo_we got %h exp 0", Rport_rd_fifo_we); end
      n_checks++; if (Wport_wr_burst_finish !== 4'h0 || Rport_rd_burst_finish !== 5'h0) begin
         n_fail++; $display("FAIL rst_finish got w=%h r=%h exp 0", Wport_wr_burst_finish, Rport_rd_burst_finish); end
      wr_fifo_re = 1'b0; rd_fifo_we = 1'b0; wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
      ui_rst = 1'b0;
      tick();
      $display("txn reset released");
   endtask

   task automatic test_single_write();
      logic [DW-1:0] exp_d;
      exp_d = {8{32'hD000_0002}};
      w_req(2, 32'h0000_1000, 10'd16);            // request in cycle N, now in N+1
      settle();
      n_checks++; if (wr_burst_req !== 1'b0) begin n_fail++; $display("FAIL lat_n1_req got %b exp 0", wr_burst_req); end
      n_checks++; if (Wport_wr_ready !== 4'b1011) begin n_fail++; $display("FAIL lat_n1_ready got %b exp 1011", Wport_wr_ready); end
      tick();                                      // N+2
      n_checks++; if (wr_burst_req !== 1'b1) begin n_fail++; $display("FAIL lat_n2_req got %b exp 1", wr_burst_req); end
      n_checks++; if (wr_burst_addr !== 32'h1000) begin n_fail++; $display("FAIL single_addr got %h exp 1000", wr_burst_addr); end
      n_checks++; if (wr_burst_len !== 10'd16) begin n_fail++; $display("FAIL single_len got %0d exp 16", wr_burst_len); end
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      wr_fifo_re = 1'b1;
      settle();
      n_checks++; if (Wport_wr_fifo_re !== 4'b0100) begin n_fail++; $display("FAIL single_re got %b exp 0100", Wport_wr_fifo_re); end
      n_checks++; if (wr_fifo_data !== exp_d) begin n_fail++; $display("FAIL single_data got %h exp %h", wr_fifo_data[31:0], exp_d[31:0]); end
      n_checks++; if (wr_burst_req !== 1'b0) begin n_fail++; $display("FAIL single_busy_req got %b exp 0", wr_burst_req); end
      tick();
      wr_fifo_re = 1'b0;
      wr_burst_finish = 1'b1;
      settle();
      n_checks++; if (Wport_wr_burst_finish !== 4'b0100) begin n_fail++; $display("FAIL single_finish got %b exp 0100", Wport_wr_burst_finish); end
      tick();
      wr_burst_finish = 1'b0;
      settle();
      n_checks++; if (Wport_wr_burst_finish !== 4'b0000) begin n_fail++; $display("FAIL single_finish_1cyc got %b exp 0000", Wport_wr_burst_finish); end
      n_checks++; if (Wport_wr_ready !== 4'hF) begin n_fail++; $display("FAIL single_ready_back got %b exp 1111", Wport_wr_ready); end
      n_checks++; if (wr_fifo_data !== '0) begin n_fail++; $display("FAIL single_idle_data got %h exp 0", wr_fifo_data[31:0]); end
      $display("txn single write ch2 addr=1000 len=16 done");
   endtask

   task automatic test_rr_order();
      int order [5];
      bit ok;
      logic [AW-1:0] ea;
      order = '{0, 1, 2, 3, 0};
      ui_rst = 1'b1;
      tick();
      ui_rst = 1'b0;
      for (int k = 0; k < WN; k++) begin
         Wport_wr_burst_addr[k*AW +: AW] = 32'h3000 + 32'(k) * 32'h100;
         Wport_wr_burst_len[k*LW +: LW]  = LW'(k + 1);
      end
      Wport_wr_burst_req = 4'hF;
      tick();
      Wport_wr_burst_req = '0;
      for (int j = 0; j < 5; j++) begin
         ea = 32'h3000 + 32'(order[j]) * 32'h100;
         wait_wr_issue(ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_issue_wait got timeout exp wr_burst_req"); end
         n_checks++; if (wr_burst_addr !== ea) begin n_fail++; $display("FAIL rr_addr slot%0d got %h exp %h", j, wr_burst_addr, ea); end
         $display("txn rr slot %0d addr=%h", j, wr_burst_addr);
         wr_ready = 1'b1;
         tick();
         wr_ready = 1'b0;
         repeat (20) tick();
         wr_burst_finish = 1'b1;
         settle();
         n_checks++; if (Wport_wr_burst_finish !== 4'(1 << order[j])) begin
            n_fail++; $display("FAIL rr_finish slot%0d got %b exp %b", j, Wport_wr_burst_finish, 4'(1 << order[j])); end
         tick();
         wr_burst_finish = 1'b0;
         if (j == 0) begin
            Wport_wr_burst_req = 4'b0001;
            tick();
            Wport_wr_burst_req = '0;
         end
      end
   endtask

   task automatic test_issue_stall();
      bit ok;
      int bad;
      w_req(1, 32'h0000_2222, 10'd5);
      wait_wr_issue(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_issue_wait got timeout exp wr_burst_req"); end
      wr_fifo_re = 1'b1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         settle();
         if (wr_burst_req !== 1'b1 || wr_burst_addr !== 32'h2222 || Wport_wr_fifo_re !== 4'h0) bad++;
         tick();
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
      wr_ready = 1'b1;
      settle();
      n_checks++; if (Wport_wr_fifo_re !== 4'h0) begin n_fail++; $display("FAIL stall_hs_re got %b exp 0000", Wport_wr_fifo_re); end
      tick();
      wr_ready = 1'b0;
      settle();
      n_checks++; if (Wport_wr_fifo_re !== 4'b0010) begin n_fail++; $display("FAIL stall_busy_re got %b exp 0010", Wport_wr_fifo_re); end
      n_checks++; if (wr_burst_req !== 1'b0) begin n_fail++; $display("FAIL stall_busy_req got %b exp 0", wr_burst_req); end
      wr_fifo_re = 1'b0;
      wr_burst_finish = 1'b1;
      tick();
      wr_burst_finish = 1'b0;
      $display("txn stalled write ch1 addr=2222 done");
   endtask

   task automatic test_read_we();
      bit ok;
      int we_cnt;
      int bad_we;
      int bad_re;
      int bad_bc;
      logic prev_we;
      Rport_rd_burst_addr[4*AW +: AW] = 32'h4000;
      Rport_rd_burst_len[4*LW +: LW]  = 10'd8;
      Rport_rd_burst_req = 5'b10000;
      Wport_wr_burst_addr[3*AW +: AW] = 32'h5000;
      Wport_wr_burst_len[3*LW +: LW]  = 10'd8;
      Wport_wr_burst_req = 4'b1000;
      tick();
      Rport_rd_burst_req = '0;
      Wport_wr_burst_req = '0;
      wait_rd_issue(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_issue_wait got timeout exp rd_burst_req"); end
      n_checks++; if (rd_burst_addr !== 32'h4000 || rd_burst_len !== 10'd8) begin
         n_fail++; $display("FAIL rd_addr got %h/%0d exp 4000/8", rd_burst_addr, rd_burst_len); end
      n_checks++; if (wr_burst_req !== 1'b1 || wr_burst_addr !== 32'h5000) begin
         n_fail++; $display("FAIL rw_parallel_issue got %b/%h exp 1/5000", wr_burst_req, wr_burst_addr); end
      rd_ready = 1'b1; wr_ready = 1'b1;
      tick();
      rd_ready = 1'b0; wr_ready = 1'b0;
      we_cnt = 0; bad_we = 0; bad_re = 0; bad_bc = 0; prev_we = 1'b0;
      wr_fifo_re = 1'b1;
      for (int b = 0; b < 16; b++) begin
         rd_fifo_we   = (b % 2 == 0);
         rd_fifo_data = {8{32'hBEEF_0000 + 32'(b)}};
         settle();
         if (Rport_rd_fifo_we !== (rd_fifo_we ? 5'b10000 : 5'b00000)) bad_we++;
         if (Rport_rd_fifo_we[4] === 1'b1 && prev_we === 1'b0) we_cnt++;
         prev_we = Rport_rd_fifo_we[4];
         if (Rport_rd_fifo_data[2*DW +: DW] !== rd_fifo_data) bad_bc++;
         if (Wport_wr_fifo_re !== 4'b1000) bad_re++;
         tick();
      end
      rd_fifo_we = 1'b0;
      wr_fifo_re = 1'b0;
      n_checks++; if (bad_we != 0) begin n_fail++; $display("FAIL rd_we_route got %0d bad cycles exp 0", bad_we); end
      n_checks++; if (we_cnt != 8) begin n_fail++; $display("FAIL rd_we_toggles got %0d exp 8", we_cnt); end
      n_checks++; if (bad_bc != 0) begin n_fail++; $display("FAIL rd_broadcast got %0d bad cycles exp 0", bad_bc); end
      n_checks++; if (bad_re != 0) begin n_fail++; $display("FAIL wr_concurrent_re got %0d bad cycles exp 0", bad_re); end
      rd_burst_finish = 1'b1;
      settle();
      n_checks++; if (Rport_rd_burst_finish !== 5'b10000) begin n_fail++; $display("FAIL rd_finish got %b exp 10000", Rport_rd_burst_finish); end
      tick();
      rd_burst_finish = 1'b0;
      wr_burst_finish = 1'b1;
      settle();
      n_checks++; if (Wport_wr_burst_finish !== 4'b1000) begin n_fail++; $display("FAIL rw_wr_finish got %b exp 1000", Wport_wr_burst_finish); end
      tick();
      wr_burst_finish = 1'b0;
      $display("txn read ch4 8 beats + write ch3 done");
   endtask

   task automatic test_rd_flush();
      bit ok;
      Rport_rd_burst_addr[1*AW +: AW] = 32'h6000;
      Rport_rd_burst_req = 5'b00010;
      Wport_wr_burst_addr[0 +: AW] = 32'h7000;
      Wport_wr_burst_req = 4'b0001;
      tick();
      Rport_rd_burst_req = '0;
      Wport_wr_burst_req = '0;
      wait_rd_issue(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_issue_wait got timeout exp rd_burst_req"); end
      rd_ready = 1'b1; wr_ready = 1'b1;
      tick();
      rd_ready = 1'b0; wr_ready = 1'b0;
      rd_rst = 1'b1; rd_burst_finish = 1'b1; rd_fifo_we = 1'b1;
      settle();
      n_checks++; if (Rport_rd_burst_finish !== 5'h0) begin n_fail++; $display("FAIL flush_finish got %b exp 00000", Rport_rd_burst_finish); end
      n_checks++; if (Rport_rd_fifo_we !== 5'h0) begin n_fail++; $display("FAIL flush_we got %b exp 00000", Rport_rd_fifo_we); end
      tick();
      rd_rst = 1'b0; rd_burst_finish = 1'b0; rd_fifo_we = 1'b0;
      settle();
      n_checks++; if (Rport_rd_ready !== 5'h1F) begin n_fail++; $display("FAIL flush_ready got %b exp 11111", Rport_rd_ready); end
      n_checks++; if (rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL flush_req got %b exp 0", rd_burst_req); end
      repeat (3) tick();
      n_checks++; if (rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL flush_req_later got %b exp 0", rd_burst_req); end
      n_checks++; if (Wport_wr_ready !== 4'b1110) begin n_fail++; $display("FAIL flush_wr_pending got %b exp 1110", Wport_wr_ready); end
      wr_burst_finish = 1'b1;
      settle();
      n_checks++; if (Wport_wr_burst_finish !== 4'b0001) begin n_fail++; $display("FAIL flush_wr_finish got %b exp 0001", Wport_wr_burst_finish); end
      tick();
      wr_burst_finish = 1'b0;
      $display("txn rd_rst flush during read ch1, write ch0 completed");
   endtask

   task automatic test_timeout();
      bit ok;
      int early;
      w_req(2, 32'h0000_8000, 10'd4);
      wait_wr_issue(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL to_issue_wait got timeout exp wr_burst_req"); end
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      // now BUSY cycle 0; channel 3 queues up behind the stuck burst
      Wport_wr_burst_addr[3*AW +: AW] = 32'h9000;
      Wport_wr_burst_req = 4'b1000;
      early = 0;
`ifdef DDR_ARB_TIMEOUT_EN
      for (int c = 0; c < TO - 1; c++) begin
         settle();
         if (arb_timeout !== 2'b00 || Wport_wr_burst_finish !== 4'h0) early++;
         tick();
         Wport_wr_burst_req = '0;
      end
      settle();                                    // BUSY cycle 63
      n_checks++; if (early != 0) begin n_fail++; $display("FAIL to_early got %0d bad cycles exp 0", early); end
      n_checks++; if (arb_timeout !== 2'b01) begin n_fail++; $display("FAIL to_pulse got %b exp 01", arb_timeout); end
      n_checks++; if (Wport_wr_burst_finish !== 4'b0100) begin n_fail++; $display("FAIL to_finish got %b exp 0100", Wport_wr_burst_finish); end
      tick();
      settle();
      n_checks++; if (arb_timeout !== 2'b00) begin n_fail++; $display("FAIL to_pulse_1cyc got %b exp 00", arb_timeout); end
      n_checks++; if (Wport_wr_ready !== 4'b0111) begin n_fail++; $display("FAIL to_pending got %b exp 0111", Wport_wr_ready); end
      wait_wr_issue(ok);
      n_checks++; if (!ok || wr_burst_addr !== 32'h9000) begin n_fail++; $display("FAIL to_next_grant got %b/%h exp 1/9000", ok, wr_burst_addr); end
      wr_burst_finish = 1'b1;                      // late finish while next burst is only issuing
      settle();
      n_checks++; if (Wport_wr_burst_finish !== 4'h0) begin n_fail++; $display("FAIL to_late_finish got %b exp 0000", Wport_wr_burst_finish); end
      tick();
      wr_burst_finish = 1'b0;
      $display("txn watchdog on ch2, ch3 granted next");
`else
      for (int c = 0; c < TO + 6; c++) begin
         settle();
         if (arb_timeout !== 2'b00 || Wport_wr_burst_finish !== 4'h0) early++;
         tick();
         Wport_wr_burst_req = '0;
      end
      n_checks++; if (early != 0) begin n_fail++; $display("FAIL nowd_quiet got %0d bad cycles exp 0", early); end
      n_checks++; if (Wport_wr_ready !== 4'b0011 || wr_burst_req !== 1'b0) begin
         n_fail++; $display("FAIL nowd_still_busy got %b/%b exp 0011/0", Wport_wr_ready, wr_burst_req); end
      wr_burst_finish = 1'b1;
      settle();
      n_checks++; if (Wport_wr_burst_finish !== 4'b0100) begin n_fail++; $display("FAIL nowd_finish got %b exp 0100", Wport_wr_burst_finish); end
      tick();
      wr_burst_finish = 1'b0;
      wait_wr_issue(ok);
      n_checks++; if (!ok || wr_burst_addr !== 32'h9000) begin n_fail++; $display("FAIL nowd_next_grant got %b/%h exp 1/9000", ok, wr_burst_addr); end
      $display("txn long busy ch2 without watchdog, ch3 granted next");
`endif
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      wr_burst_finish = 1'b1;
      settle();
      n_checks++; if (Wport_wr_burst_finish !== 4'b1000) begin n_fail++; $display("FAIL to_ch3_finish got %b exp 1000", Wport_wr_burst_finish); end
      tick();
      wr_burst_finish = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < WN; i++) Wport_wr_fifo_data[i*DW +: DW] = {8{32'hD000_0000 | 32'(i)}};
      test_reset();
      test_single_write();
      test_rr_order();
      test_issue_stall();
      test_read_we();
      test_rd_flush();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got stuck exp completion");
      $fatal(1, "simulation time limit");
   end

endmodule
